scie_arbiter: RTL and testbench
===============================

SCIE_ARBITER -- requirements
Module: scie_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of insn, rs1, rs2 and rd.
REQ-002 The block SHALL have parameter LATENCY, default 2: cycles from scie_valid high to scie_rd valid in the shared SCIEPipelined unit; legal range 1-8.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
REQ-004 The block SHALL have requester ports pN, N in {0,1}:
- pN_req_valid  in  1  request present.
- pN_req_ready  out  1  request accepted this cycle when valid is also high.
- pN_req_insn  in  XLEN  SCIE instruction word.
- pN_req_rs1  in  XLEN  operand 1.
- pN_req_rs2  in  XLEN  operand 2.
- pN_req_lock  in  1  keep the grant after this request.
- pN_resp_valid  out  1  one-cycle result strobe; no backpressure.
- pN_resp_rd  out  XLEN  result.
REQ-005 The block SHALL have SCIE-side ports:
- scie_valid  out  1  issue strobe.
- scie_insn  out  XLEN  issued instruction.
- scie_rs1  out  XLEN  issued operand 1.
- scie_rs2  out  XLEN  issued operand 2.
- scie_rd  in  XLEN  SCIE result.
REQ-006 The block SHALL have status ports:
- busy  out  1  any request in flight.
- lock_active  out  1  a lock is held.
- lock_owner  out  1  holder of the lock; valid only while lock_active is high.

Function
REQ-007 The block SHALL accept at most one request per cycle; acceptance means pN_req_valid && pN_req_ready at a rising edge.
REQ-008 pN_req_ready SHALL be combinational from the grant and SHALL be high for at most one port per cycle; ready MAY be high while valid is low.
REQ-009 With no lock held and both ports valid, the grant SHALL go to the port not granted most recently (round robin); with one port valid, that port SHALL be granted.
REQ-010 The last-grant pointer SHALL update only on acceptance.
REQ-011 An accepted request with req_lock=1 SHALL set lock_active=1 and lock_owner=N.
REQ-012 While the lock is held, only lock_owner SHALL be granted, including across idle cycles.
REQ-013 An accepted request from the owner with req_lock=0 SHALL release the lock after that request.
REQ-014 The issue path SHALL be registered: a request accepted in cycle C SHALL drive scie_valid=1 and its insn/rs1/rs2 on scie_* during cycle C+1.
REQ-015 In cycles with no issue, scie_valid SHALL be 0 and scie_insn/rs1/rs2 SHALL hold their previous values.
REQ-016 A LATENCY+1 deep shift register of {valid, port id} SHALL track in-flight requests.
REQ-017 scie_rd SHALL be sampled at the end of cycle C+1+LATENCY.
REQ-018 The result SHALL be presented as pN_resp_valid=1 for exactly cycle C+2+LATENCY on the originating port, with pN_resp_rd registered.
REQ-019 With LATENCY=2, the total accept-to-response latency SHALL be 4 cycles.
REQ-020 pN_resp_rd SHALL hold its last value when pN_resp_valid=0.
REQ-021 Back-to-back accepts SHALL yield back-to-back responses in issue order.
REQ-022 A response and a new acceptance in the same cycle SHALL both proceed.
REQ-023 busy SHALL be the OR of the tracking-register valid bits and the response-stage valid bit.
REQ-024 pN_req_valid deasserted without acceptance SHALL carry no state.
REQ-025 A request SHALL NOT be issued twice.

Reset
REQ-026 While reset is high, all pN_req_ready, pN_resp_valid, scie_valid, busy and lock_active SHALL be 0.
REQ-027 While reset is high, scie_insn/rs1/rs2, pN_resp_rd and lock_owner SHALL be 0, and the last-grant pointer SHALL be set to 1 so that port 0 wins first.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight tags: no response is delivered for them, and any lock is cleared.
REQ-029 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
The bench SHALL model SCIE as rd = rs1 + rs2, delayed LATENCY=2 cycles.
REQ-030 Single request: p0 sends insn=11, rs1=5, rs2=0 in cycle C -> scie_valid in C+1; p0_resp_valid=1 with rd=5 in C+4; p1_resp_valid stays 0.
REQ-031 Contention: p0 and p1 both valid continuously, insn=43, rs1=99 and rs1=47, rs2=1 and rs2=2 -> accepts alternate p0, p1, p0, ...; responses 100 and 49 arrive on the matching ports in order, one per cycle.
REQ-032 Lock: p1 sends 3 requests with lock=1,1,0 while p0 is valid throughout -> p0_req_ready stays 0 until the third p1 request is accepted; lock_active is high for exactly 2 cycles after the first accept, then p0 is granted.
REQ-033 Reset mid-flight: accept p0 (rs1=41, rs2=3), assert reset 2 cycles later for 1 cycle -> no p0_resp_valid ever; busy=0 and lock_active=0 after reset.
REQ-034 Idle lock hold: p0 sends lock=1, then idles 5 cycles while p1 is valid -> p1_req_ready stays 0 for all 5 cycles; p0 then sends lock=0 -> p1 is accepted in the following cycle.

Source files
------------

// File: rtl/scie_arbiter.sv
// Two-port arbiter in front of a shared, fixed-latency SCIE unit.
// Round-robin grant with an optional sticky lock, a registered issue stage,
// and a tag pipeline that routes each result back to the port that sent it.
module scie_arbiter #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            p0_req_valid,
  output logic            p0_req_ready,
  input  logic [XLEN-1:0] p0_req_insn,
  input  logic [XLEN-1:0] p0_req_rs1,
  input  logic [XLEN-1:0] p0_req_rs2,
  input  logic            p0_req_lock,
  output logic            p0_resp_valid,
  output logic [XLEN-1:0] p0_resp_rd,

  input  logic            p1_req_valid,
  output logic            p1_req_ready,
  input  logic [XLEN-1:0] p1_req_insn,
  input  logic [XLEN-1:0] p1_req_rs1,
  input  logic [XLEN-1:0] p1_req_rs2,
  input  logic            p1_req_lock,
  output logic            p1_resp_valid,
  output logic [XLEN-1:0] p1_resp_rd,

  output logic            scie_valid,
  output logic [XLEN-1:0] scie_insn,
  output logic [XLEN-1:0] scie_rs1,
  output logic [XLEN-1:0] scie_rs2,
  input  logic [XLEN-1:0] scie_rd,

  output logic            busy,
  output logic            lock_active,
  output logic            lock_owner
);

  // Arbitration state
  logic            last_grant_q;
  logic            lock_active_q;
  logic            lock_owner_q;

  // Issue stage registers
  logic            scie_valid_q;
  logic [XLEN-1:0] scie_insn_q;
  logic [XLEN-1:0] scie_rs1_q;
  logic [XLEN-1:0] scie_rs2_q;

  // In-flight tags: stage 0 lines up with the issue cycle, stage LATENCY
  // lines up with the cycle in which scie_rd carries that request's result
  logic [LATENCY:0] tag_valid_q;
  logic [LATENCY:0] tag_port_q;

  // Response stage
  logic            resp0_valid_q;
  logic            resp1_valid_q;
  logic [XLEN-1:0] resp0_rd_q;
  logic [XLEN-1:0] resp1_rd_q;

  // Grant decision
  logic            grant_en;
  logic            grant_port;
  logic            accept;
  logic            sel_lock;
  logic [XLEN-1:0] sel_insn;
  logic [XLEN-1:0] sel_rs1;
  logic [XLEN-1:0] sel_rs2;

  // Pick the granted port: the lock owner wins outright (even when idle),
  // otherwise round robin between valid requesters
  always_comb begin
    grant_en   = 1'b0;
    grant_port = 1'b0;
    if (lock_active_q) begin
      grant_en   = 1'b1;
      grant_port = lock_owner_q;
    end else if (p0_req_valid && p1_req_valid) begin
      grant_en   = 1'b1;
      grant_port = ~last_grant_q;
    end else if (p0_req_valid) begin
      grant_en   = 1'b1;
      grant_port = 1'b0;
    end else if (p1_req_valid) begin
      grant_en   = 1'b1;
      grant_port = 1'b1;
    end
  end

  assign p0_req_ready = !reset && grant_en && !grant_port;
  assign p1_req_ready = !reset && grant_en &&  grant_port;
  assign accept       = (p0_req_ready && p0_req_valid) || (p1_req_ready && p1_req_valid);

  assign sel_lock = grant_port ? p1_req_lock : p0_req_lock;
  assign sel_insn = grant_port ? p1_req_insn : p0_req_insn;
  assign sel_rs1  = grant_port ? p1_req_rs1  : p0_req_rs1;
  assign sel_rs2  = grant_port ? p1_req_rs2  : p0_req_rs2;

  // Round-robin pointer and lock ownership move only on an accepted request;
  // an owner request without lock releases it after that request
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q  <= 1'b1;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant_port;
      if (sel_lock) begin
        lock_active_q <= 1'b1;
        lock_owner_q  <= grant_port;
      end else begin
        lock_active_q <= 1'b0;
      end
    end
  end

  // Registered issue toward the SCIE unit; operands hold between issues
  always_ff @(posedge clock) begin
    if (reset) begin
      scie_valid_q <= 1'b0;
      scie_insn_q  <= '0;
      scie_rs1_q   <= '0;
      scie_rs2_q   <= '0;
    end else begin
      scie_valid_q <= accept;
      if (accept) begin
        scie_insn_q <= sel_insn;
        scie_rs1_q  <= sel_rs1;
        scie_rs2_q  <= sel_rs2;
      end
    end
  end

  // Shift the {valid, port} tag of every accepted request down the pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid_q <= '0;
      tag_port_q  <= '0;
    end else begin
      tag_valid_q <= {tag_valid_q[LATENCY-1:0], accept};
      tag_port_q  <= {tag_port_q[LATENCY-1:0], grant_port};
    end
  end

  // Capture scie_rd for the tag at the end of the pipe into its port's
  // result register and raise that port's strobe for one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rd_q    <= '0;
      resp1_rd_q    <= '0;
    end else begin
      resp0_valid_q <= tag_valid_q[LATENCY] && !tag_port_q[LATENCY];
      resp1_valid_q <= tag_valid_q[LATENCY] &&  tag_port_q[LATENCY];
      if (tag_valid_q[LATENCY] && !tag_port_q[LATENCY]) begin
        resp0_rd_q <= scie_rd;
      end
      if (tag_valid_q[LATENCY] && tag_port_q[LATENCY]) begin
        resp1_rd_q <= scie_rd;
      end
    end
  end

  // Outputs read as idle/zero for the whole time reset is held, not just
  // after the first reset edge
  assign scie_valid    = !reset && scie_valid_q;
  assign scie_insn     = reset ? '0 : scie_insn_q;
  assign scie_rs1      = reset ? '0 : scie_rs1_q;
  assign scie_rs2      = reset ? '0 : scie_rs2_q;
  assign p0_resp_valid = !reset && resp0_valid_q;
  assign p1_resp_valid = !reset && resp1_valid_q;
  assign p0_resp_rd    = reset ? '0 : resp0_rd_q;
  assign p1_resp_rd    = reset ? '0 : resp1_rd_q;
  assign busy          = !reset && ((|tag_valid_q) || resp0_valid_q || resp1_valid_q);
  assign lock_active   = !reset && lock_active_q;
  assign lock_owner    = !reset && lock_owner_q;

endmodule

// File: tb/tb_scie_arbiter.sv
// Directed bench for scie_arbiter: a small SCIE model (rd = rs1 + rs2 after
// LATENCY cycles), expected responses queued as requests are issued, and a
// monitor that pops and compares on every response strobe.
module tb_scie_arbiter;
  localparam int XLEN    = 32;
  localparam int LATENCY = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic            p0_req_ready, p1_req_ready;
  logic [XLEN-1:0] p0_req_insn = '0, p0_req_rs1 = '0, p0_req_rs2 = '0;
  logic [XLEN-1:0] p1_req_insn = '0, p1_req_rs1 = '0, p1_req_rs2 = '0;
  logic            p0_req_lock = 1'b0, p1_req_lock = 1'b0;
  logic            p0_resp_valid, p1_resp_valid;
  logic [XLEN-1:0] p0_resp_rd, p1_resp_rd;
  logic            scie_valid;
  logic [XLEN-1:0] scie_insn, scie_rs1, scie_rs2, scie_rd;
  logic            busy, lock_active, lock_owner;

  typedef struct {
    logic            port;
    logic [XLEN-1:0] rd;
  } resp_t;

  resp_t exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  logic [XLEN-1:0] model_pipe [LATENCY] = '{default: '0};

  scie_arbiter #(.XLEN(XLEN), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_insn(p0_req_insn), .p0_req_rs1(p0_req_rs1), .p0_req_rs2(p0_req_rs2),
    .p0_req_lock(p0_req_lock), .p0_resp_valid(p0_resp_valid), .p0_resp_rd(p0_resp_rd),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_insn(p1_req_insn), .p1_req_rs1(p1_req_rs1), .p1_req_rs2(p1_req_rs2),
    .p1_req_lock(p1_req_lock), .p1_resp_valid(p1_resp_valid), .p1_resp_rd(p1_resp_rd),
    .scie_valid(scie_valid), .scie_insn(scie_insn), .scie_rs1(scie_rs1),
    .scie_rs2(scie_rs2), .scie_rd(scie_rd),
    .busy(busy), .lock_active(lock_active), .lock_owner(lock_owner)
  );

  always #5 clock = ~clock;

  // SCIE model: sum captured at the end of the issue cycle, shown on scie_rd
  // LATENCY cycles after issue
  always @(posedge clock) begin
    if (scie_valid) model_pipe[0] <= scie_rs1 + scie_rs2;
    for (int i = 1; i < LATENCY; i++) model_pipe[i] <= model_pipe[i-1];
  end
  assign scie_rd = model_pipe[LATENCY-1];

  task automatic check_output(input string name, input logic [XLEN-1:0] actual,
                              input logic [XLEN-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic port, input logic valid, input logic [XLEN-1:0] insn,
                                input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                input logic lock);
    if (port) begin
      p1_req_valid = valid; p1_req_insn = insn; p1_req_rs1 = rs1; p1_req_rs2 = rs2; p1_req_lock = lock;
    end else begin
      p0_req_valid = valid; p0_req_insn = insn; p0_req_rs1 = rs1; p0_req_rs2 = rs2; p0_req_lock = lock;
    end
  endtask

  task automatic expect_resp(input logic port, input logic [XLEN-1:0] rd);
    resp_t item;
    item.port = port;
    item.rd   = rd;
    exp_q.push_back(item);
  endtask

  // Monitor: every response strobe must match the oldest queued expectation
  always @(negedge clock) begin
    resp_t item;
    if (p0_resp_valid || p1_resp_valid) begin
      check_output("resp_both_ports", {31'd0, p0_resp_valid & p1_resp_valid}, 0);
      if (exp_q.size() == 0) begin
        check_output("resp_unexpected", {31'd0, p1_resp_valid}, {31'd0, ~p1_resp_valid});
      end else begin
        item = exp_q.pop_front();
        check_output("resp_port", {31'd0, p1_resp_valid}, {31'd0, item.port});
        check_output("resp_rd", item.port ? p1_resp_rd : p0_resp_rd, item.rd);
      end
    end
  end

  // Directed scenario sequence
  initial begin
    // Reset state, with p0 already requesting
    apply_stimulus(0, 1, 11, 5, 0, 0);
    repeat (2) tick();
    @(negedge clock);
    check_output("rst_p0_ready", p0_req_ready, 0);
    check_output("rst_scie_valid", scie_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_lock_active", lock_active, 0);
    check_output("rst_scie_insn", scie_insn, 0);
    check_output("rst_p0_resp_rd", p0_resp_rd, 0);
    check_output("rst_lock_owner", lock_owner, 0);

    // Single request, granted in the first cycle after reset
    tick();
    reset = 1'b0;
    expect_resp(0, 5);
    @(negedge clock);
    check_output("single_p0_ready", p0_req_ready, 1);
    check_output("single_p1_ready", p1_req_ready, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check_output("single_scie_valid", scie_valid, 1);
    check_output("single_scie_insn", scie_insn, 11);
    check_output("single_scie_rs1", scie_rs1, 5);
    check_output("single_scie_rs2", scie_rs2, 0);
    check_output("single_busy", busy, 1);
    tick();
    @(negedge clock);
    check_output("single_scie_idle", scie_valid, 0);
    check_output("single_insn_hold", scie_insn, 11);
    tick();
    @(negedge clock);
    check_output("single_resp_early", p0_resp_valid, 0);
    tick();
    @(negedge clock);
    check_output("single_resp_c4", p0_resp_valid, 1);
    check_output("single_p1_quiet", p1_resp_valid, 0);
    tick();
    @(negedge clock);
    check_output("single_resp_once", p0_resp_valid, 0);
    check_output("single_rd_hold", p0_resp_rd, 5);
    check_output("single_idle_busy", busy, 0);
    repeat (2) tick();

    // Contention: p0 won last, so p1 goes first and grants alternate
    apply_stimulus(0, 1, 43, 99, 1, 0);
    apply_stimulus(1, 1, 43, 47, 2, 0);
    for (int k = 0; k < 6; k++) begin
      expect_resp((k % 2) == 0, (k % 2) == 0 ? 49 : 100);
      @(negedge clock);
      check_output("cont_p1_ready", p1_req_ready, (k % 2) == 0);
      check_output("cont_p0_ready", p0_req_ready, (k % 2) == 1);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    repeat (8) tick();

    // Lock: p1 holds the grant for lock=1,1 and releases on lock=0
    apply_stimulus(0, 1, 7, 10, 1, 0);
    apply_stimulus(1, 1, 5, 20, 1, 1);
    expect_resp(1, 21); expect_resp(1, 22); expect_resp(1, 23); expect_resp(0, 11);
    @(negedge clock);
    check_output("lock_a_p1_ready", p1_req_ready, 1);
    check_output("lock_a_p0_ready", p0_req_ready, 0);
    check_output("lock_a_active", lock_active, 0);
    tick();
    apply_stimulus(1, 1, 5, 21, 1, 1);
    @(negedge clock);
    check_output("lock_b_active", lock_active, 1);
    check_output("lock_b_owner", lock_owner, 1);
    check_output("lock_b_p0_ready", p0_req_ready, 0);
    tick();
    apply_stimulus(1, 1, 5, 22, 1, 0);
    @(negedge clock);
    check_output("lock_c_active", lock_active, 1);
    check_output("lock_c_p0_ready", p0_req_ready, 0);
    check_output("lock_c_p1_ready", p1_req_ready, 1);
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    @(negedge clock);
    check_output("lock_d_active", lock_active, 0);
    check_output("lock_d_p0_ready", p0_req_ready, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    repeat (8) tick();

    // Idle lock hold: p0 keeps the grant through 5 idle cycles
    apply_stimulus(0, 1, 9, 1, 2, 1);
    expect_resp(0, 3); expect_resp(0, 8); expect_resp(1, 33);
    @(negedge clock);
    check_output("idle_p0_ready", p0_req_ready, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 9, 30, 3, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_output("idle_p1_blocked", p1_req_ready, 0);
      check_output("idle_lock_held", lock_active, 1);
      tick();
    end
    apply_stimulus(0, 1, 9, 4, 4, 0);
    @(negedge clock);
    check_output("idle_release_p0", p0_req_ready, 1);
    check_output("idle_release_p1", p1_req_ready, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check_output("idle_after_p1_ready", p1_req_ready, 1);
    check_output("idle_after_lock", lock_active, 0);
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    repeat (8) tick();

    // Reset mid-flight: locked p0 request is dropped, lock cleared
    apply_stimulus(0, 1, 13, 41, 3, 1);
    @(negedge clock);
    check_output("mid_p0_ready", p0_req_ready, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check_output("mid_busy_before", busy, 1);
    check_output("mid_lock_before", lock_active, 1);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check_output("mid_busy_in_rst", busy, 0);
    check_output("mid_lock_in_rst", lock_active, 0);
    tick();
    reset = 1'b0;
    apply_stimulus(1, 1, 17, 2, 2, 0);
    expect_resp(1, 4);
    @(negedge clock);
    check_output("mid_busy_after", busy, 0);
    check_output("mid_lock_after", lock_active, 0);
    check_output("mid_p1_ready", p1_req_ready, 1);
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    @(negedge clock);
    check_output("mid_no_p0_resp", p0_resp_valid, 0);
    repeat (8) tick();

    check_output("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
